// File: rtl/mem_dram_pkg.sv
// Shared types and constants for the SIP1M9 DRAM timing sequencer.
package mem_dram_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_PRE, S_BERR_ACK, S_REF_CAS, S_REF_RAS
  } state_t;

  localparam logic [1:0] BANK_0       = 2'd0;
  localparam logic [1:0] BANK_1       = 2'd1;
  localparam logic [1:0] BANK_2       = 2'd2;
  localparam logic [1:0] BANK_INVALID = 2'd3;

  localparam int ADDR_W  = 22;
  localparam int AA_W    = 10;
  localparam int BANK_HI = 21, BANK_LO = 20;
  localparam int ROW_HI  = 19, ROW_LO  = 10;
  localparam int COL_HI  = 9,  COL_LO  = 0;

  localparam int DEF_T_RCD     = 2;
  localparam int DEF_T_CAS     = 3;
  localparam int DEF_T_RP      = 3;
  localparam int DEF_T_CSR     = 1;
  localparam int DEF_T_RAS_REF = 3;
  localparam int DEF_T_REF     = 390;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] bank_onehot(input logic [1:0] b);
    case (b)
      BANK_0:  return 3'b001;
      BANK_1:  return 3'b010;
      BANK_2:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/mem_dram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
module mem_dram_refresh_timer
  import mem_dram_pkg::*;
#(
  parameter int T_REF = DEF_T_REF
) (
  input  logic sysclk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick,
  output logic pending
);
  localparam int W = $clog2(T_REF + 1);

  logic [W-1:0] cnt;

  // Reaching zero and reloading are merged into one edge so the period is exactly T_REF.
  assign tick = (cnt == W'(1));

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      cnt     <= W'(T_REF);
      pending <= 1'b0;
    end else begin
      cnt <= tick ? W'(T_REF) : cnt - W'(1);
      if (tick)     pending <= 1'b1;
      else if (clr) pending <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_dram_ctl.sv
// Strobe/address sequencer for three DRAM banks with CAS-before-RAS refresh.
module mem_dram_ctl
  import mem_dram_pkg::*;
#(
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_CAS     = DEF_T_CAS,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_CSR     = DEF_T_CSR,
  parameter int T_RAS_REF = DEF_T_RAS_REF,
  parameter int T_REF     = DEF_T_REF
) (
  input  logic              sysclk,
  input  logic              sys_rst,
  input  logic              REQ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  output logic              READY,
  output logic              ACK,
  output logic              BERR,
  output logic [AA_W-1:0]   AA_9_0,
  output logic              BANK0,
  output logic              BANK1,
  output logic              BANK2,
  output logic              RAS,
  output logic              CAS,
  output logic              MWRITE50_n
);
  localparam int TMAX = max2(max2(max2(T_RCD, T_CAS), max2(T_RP, T_CSR)), T_RAS_REF);
  localparam int CW   = max2(1, $clog2(TMAX));

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bank_q;
  logic [AA_W-1:0] col_q;
  logic            wr_q;
  logic            tick, pend, clr, pend_nxt;

  mem_dram_refresh_timer #(.T_REF(T_REF)) u_ref (
    .sysclk (sysclk),
    .sys_rst(sys_rst),
    .clr    (clr),
    .tick   (tick),
    .pending(pend)
  );

  // Refresh is entered from IDLE or straight out of the last precharge cycle.
  assign clr      = pend && (state == S_IDLE || (state == S_PRE && cnt == '0));
  assign pend_nxt = tick || (pend && !clr);

  assign {BANK2, BANK1, BANK0} = bank_q;

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      READY      <= 1'b0;
      ACK        <= 1'b0;
      BERR       <= 1'b0;
      AA_9_0     <= '0;
      bank_q     <= '0;
      RAS        <= 1'b0;
      CAS        <= 1'b0;
      MWRITE50_n <= 1'b1;
      col_q      <= '0;
      wr_q       <= 1'b0;
    end else begin
      ACK  <= 1'b0;
      BERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pend) begin
            state  <= S_REF_CAS;
            cnt    <= CW'(T_CSR - 1);
            CAS    <= 1'b1;
            bank_q <= 3'b111;
            READY  <= 1'b0;
          end else if (REQ && READY) begin
            READY <= 1'b0;
            wr_q  <= WRITE;
            col_q <= ADDR[COL_HI:COL_LO];
            if (ADDR[BANK_HI:BANK_LO] == BANK_INVALID) begin
              state <= S_BERR_ACK;
              ACK   <= 1'b1;
              BERR  <= 1'b1;
            end else begin
              state      <= S_ROW;
              cnt        <= CW'(T_RCD - 1);
              AA_9_0     <= ADDR[ROW_HI:ROW_LO];
              bank_q     <= bank_onehot(ADDR[BANK_HI:BANK_LO]);
              RAS        <= 1'b1;
              MWRITE50_n <= !(WRITE && (T_RCD == 1));
            end
          end else begin
            READY <= !pend_nxt;
          end
        end
        S_ROW: begin
          if (cnt == '0) begin
            state      <= S_COL;
            cnt        <= CW'(T_CAS - 1);
            AA_9_0     <= col_q;
            CAS        <= 1'b1;
            MWRITE50_n <= !wr_q;
            ACK        <= (T_CAS == 1);
          end else begin
            cnt        <= cnt - CW'(1);
            // Early write: W drops in the last row cycle so it leads CAS.
            MWRITE50_n <= !(wr_q && cnt == CW'(1));
          end
        end
        S_COL: begin
          if (cnt == '0) begin
            state      <= S_PRE;
            cnt        <= CW'(T_RP - 1);
            AA_9_0     <= '0;
            bank_q     <= '0;
            RAS        <= 1'b0;
            CAS        <= 1'b0;
            MWRITE50_n <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
            ACK <= (cnt == CW'(1));
          end
        end
        S_PRE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (pend) begin
            state  <= S_REF_CAS;
            cnt    <= CW'(T_CSR - 1);
            CAS    <= 1'b1;
            bank_q <= 3'b111;
          end else begin
            state <= S_IDLE;
            READY <= !pend_nxt;
          end
        end
        S_REF_CAS: begin
          if (cnt == '0) begin
            state <= S_REF_RAS;
            cnt   <= CW'(T_RAS_REF - 1);
            RAS   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_REF_RAS: begin
          if (cnt == '0) begin
            state  <= S_PRE;
            cnt    <= CW'(T_RP - 1);
            RAS    <= 1'b0;
            CAS    <= 1'b0;
            bank_q <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_BERR_ACK: begin
          state <= S_IDLE;
          READY <= !pend_nxt;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dram_ctl.sv
// Directed bench for mem_dram_ctl: vector table plus refresh/reset corner sequences.
module tb_mem_dram_ctl;
  logic        sysclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        REQ = 1'b0;
  logic        WRITE = 1'b0;
  logic [21:0] ADDR = '0;
  logic        READY, ACK, BERR, BANK0, BANK1, BANK2, RAS, CAS, MWRITE50_n;
  logic [9:0]  AA_9_0;

  mem_dram_ctl dut (
    .sysclk(sysclk), .sys_rst(sys_rst), .REQ(REQ), .WRITE(WRITE), .ADDR(ADDR),
    .READY(READY), .ACK(ACK), .BERR(BERR), .AA_9_0(AA_9_0),
    .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2),
    .RAS(RAS), .CAS(CAS), .MWRITE50_n(MWRITE50_n)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // Observation order: READY ACK BERR AA[9:0] BANK2 BANK1 BANK0 RAS CAS MWRITE50_n
  typedef logic [18:0] obs_t;
  obs_t obs;
  assign obs = {READY, ACK, BERR, AA_9_0, BANK2, BANK1, BANK0, RAS, CAS, MWRITE50_n};

  function automatic obs_t pk(input bit rdy, input bit ack, input bit berr,
                              input logic [9:0] aa, input logic [2:0] bk,
                              input bit ras, input bit cas, input bit mw);
    return {rdy, ack, berr, aa, bk, ras, cas, mw};
  endfunction

  task automatic chk(input string nm, input obs_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got rdy/ack/berr/aa/bank/ras/cas/mw_n=%b/%b/%b/%h/%b/%b/%b/%b want %b/%b/%b/%h/%b/%b/%b/%b",
               nm, cyc, obs[18], obs[17], obs[16], obs[15:6], obs[5:3], obs[2], obs[1], obs[0],
               exp[18], exp[17], exp[16], exp[15:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic to_cyc(input int n);
    if (cyc > n) begin
      n_chk++;
      n_fail++;
      $display("FAIL schedule cyc=%0d already past target %0d", cyc, n);
    end
    while (cyc < n) @(negedge sysclk);
  endtask

  typedef struct {
    bit          req;
    bit          wr;
    logic [21:0] addr;
    obs_t        exp;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit req, input bit wr, input logic [21:0] addr, input obs_t e);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.exp = e;
    vq.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [21:0] a_rd, a_wr, a_be;
    obs_t idle_r, idle_b;
    int r, kb, kc, rr;
    a_rd   = {2'b01, 10'h155, 10'h2AA};
    a_wr   = {2'b10, 10'h3FF, 10'h000};
    a_be   = {2'b11, 10'h0AB, 10'h0CD};
    idle_r = pk(1, 0, 0, 0, 0, 0, 0, 1);
    idle_b = pk(0, 0, 0, 0, 0, 0, 0, 1);

    // Each row: check outputs in this cycle, then drive inputs for the next edge.
    add(1, 0, a_rd, idle_r);
    repeat (2) add(1, 0, a_rd, pk(0, 0, 0, 10'h155, 3'b010, 1, 0, 1));
    repeat (2) add(1, 0, a_rd, pk(0, 0, 0, 10'h2AA, 3'b010, 1, 1, 1));
    add(1, 0, a_rd, pk(0, 1, 0, 10'h2AA, 3'b010, 1, 1, 1));
    repeat (3) add(1, 0, a_rd, idle_b);
    add(1, 1, a_wr, idle_r);
    add(1, 1, a_wr, pk(0, 0, 0, 10'h3FF, 3'b100, 1, 0, 1));
    add(1, 1, a_wr, pk(0, 0, 0, 10'h3FF, 3'b100, 1, 0, 0));
    repeat (2) add(1, 1, a_wr, pk(0, 0, 0, 10'h000, 3'b100, 1, 1, 0));
    add(1, 1, a_wr, pk(0, 1, 0, 10'h000, 3'b100, 1, 1, 0));
    repeat (3) add(1, 1, a_wr, idle_b);
    add(1, 0, a_be, idle_r);
    add(0, 0, '0, pk(0, 1, 1, 0, 0, 0, 0, 1));
    add(0, 0, '0, idle_r);

    repeat (3) @(negedge sysclk);
    sys_rst = 1'b0;
    r = cyc;
    chk("reset", idle_b);

    foreach (vq[i]) begin
      @(negedge sysclk);
      chk($sformatf("vec%0d", i), vq[i].exp);
      REQ = vq[i].req; WRITE = vq[i].wr; ADDR = vq[i].addr;
    end

    // Refresh from idle, request raised as the tick lands
    to_cyc(r + 389); chk("ref_before_tick", idle_r);
    to_cyc(r + 390); chk("ref_pending", idle_b);
    REQ = 1'b1; WRITE = 1'b0; ADDR = {2'b00, 10'h0F0, 10'h00F};
    to_cyc(r + 391); chk("ref_cas", pk(0, 0, 0, 0, 3'b111, 0, 1, 1));
    for (int j = 2; j <= 4; j++) begin
      to_cyc(r + 390 + j); chk($sformatf("ref_ras%0d", j), pk(0, 0, 0, 0, 3'b111, 1, 1, 1));
    end
    for (int j = 5; j <= 7; j++) begin
      to_cyc(r + 390 + j); chk($sformatf("ref_pre%0d", j), idle_b);
    end
    to_cyc(r + 398); chk("ref_done_ready", idle_r);
    to_cyc(r + 399); chk("ref_then_row", pk(0, 0, 0, 10'h0F0, 3'b001, 1, 0, 1));
    REQ = 1'b0;

    // Tick lands in COL of a read (next tick edge r+779 = kb+3)
    kb = r + 776;
    to_cyc(kb); chk("b_ready", idle_r);
    REQ = 1'b1; WRITE = 1'b0; ADDR = {2'b01, 10'h011, 10'h022};
    to_cyc(kb + 1); REQ = 1'b0;
    to_cyc(kb + 4); chk("b_col", pk(0, 0, 0, 10'h022, 3'b010, 1, 1, 1));
    to_cyc(kb + 5); chk("b_ack", pk(0, 1, 0, 10'h022, 3'b010, 1, 1, 1));
    to_cyc(kb + 6); chk("b_pre0", idle_b);
    REQ = 1'b1; ADDR = {2'b00, 10'h001, 10'h002};
    to_cyc(kb + 8); chk("b_pre2", idle_b);
    to_cyc(kb + 9); chk("b_ref_cas", pk(0, 0, 0, 0, 3'b111, 0, 1, 1));
    REQ = 1'b0;
    to_cyc(kb + 10); chk("b_ref_ras", pk(0, 0, 0, 0, 3'b111, 1, 1, 1));
    to_cyc(kb + 16); chk("b_ready_after", idle_r);

    // Reset during COL of a write
    kc = kb + 20;
    to_cyc(kc); chk("c_ready", idle_r);
    REQ = 1'b1; WRITE = 1'b1; ADDR = {2'b00, 10'h2A5, 10'h15A};
    to_cyc(kc + 1); REQ = 1'b0; chk("c_row", pk(0, 0, 0, 10'h2A5, 3'b001, 1, 0, 1));
    to_cyc(kc + 3); chk("c_col", pk(0, 0, 0, 10'h15A, 3'b001, 1, 1, 0));
    sys_rst = 1'b1;
    to_cyc(kc + 4); chk("c_reset", idle_b);
    sys_rst = 1'b0;
    rr = kc + 4;
    to_cyc(kc + 5); chk("c_no_ack_ready", idle_r);
    to_cyc(rr + 389); chk("c_before_tick", idle_r);
    to_cyc(rr + 390); chk("c_pending", idle_b);
    to_cyc(rr + 391); chk("c_ref_cas", pk(0, 0, 0, 0, 3'b111, 0, 1, 1));
    to_cyc(rr + 398); chk("c_ready_after", idle_r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_dram_ctl.md
Name: mem_dram_ctl

Overview:
Timing sequencer for the three-bank SIP1M9 DRAM array (BANK0..2, 18-bit DD bus). Accepts single-word read/write requests from the memory-bus side and produces a multiplexed row/column address on AA_9_0, one-hot bank select, active-high RAS/CAS and MWRITE50_n. Also issues periodic CAS-before-RAS refresh to all banks, with refresh taking priority over new requests. The block drives only strobes and addresses; it never touches DD.

Parameters:
T_RCD, 2, cycles RAS-only (row phase) before CAS
T_CAS, 3, cycles CAS asserted (column phase)
T_RP, 3, precharge cycles with RAS=CAS=0 after any cycle
T_CSR, 1, refresh cycles CAS asserted before RAS
T_RAS_REF, 3, refresh cycles with RAS and CAS both asserted
T_REF, 390, refresh interval in clocks (15.6 us at 25 MHz); must exceed 1+T_RCD+T_CAS+T_RP

Ports:
sysclk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
REQ  in  1  request valid
WRITE  in  1  1=write, 0=read; sampled with REQ
ADDR  in  22  [21:20] bank, [19:10] row, [9:0] column
READY  out  1  controller can accept REQ this cycle
ACK  out  1  one-cycle completion pulse; read data valid on DD in this cycle
BERR  out  1  pulses with ACK when bank field = 3
AA_9_0  out  10  multiplexed DRAM address
BANK0  out  1  bank 0 select
BANK1  out  1  bank 1 select
BANK2  out  1  bank 2 select
RAS  out  1  row strobe, active-high (gated to RAS_n per bank externally)
CAS  out  1  column strobe, active-high
MWRITE50_n  out  1  DRAM write enable, active-low

Behaviour:
- Interface: one clock sysclk; reset sys_rst is synchronous and active-high.
- Reset values: READY=0 during reset, 1 the first cycle after; ACK=BERR=0; AA_9_0=0; BANK0..2=0; RAS=CAS=0; MWRITE50_n=1; FSM=IDLE; refresh counter reloaded to T_REF; refresh-pending=0.
- Handshake: transfer accepted on edge where REQ&&READY; ADDR/WRITE captured into registers then. READY=1 only in IDLE with refresh-pending=0. REQ may change freely when READY=0.
- States: IDLE, ROW, COL, PRE, BERR_ACK, REF_CAS, REF_RAS.
- Accept at edge k, bank 0..2: ROW cycles k+1..k+T_RCD: AA=row, selected BANKn=1, RAS=1. COL cycles k+T_RCD+1..k+T_RCD+T_CAS: AA=col, RAS=CAS=1, BANKn held. ACK=1 in last COL cycle (k+5 default). PRE T_RP cycles: all strobes/banks 0, AA=0. Then IDLE (READY at k+9 default).
- Write: MWRITE50_n=0 from last ROW cycle through last COL cycle (early write, W low before CAS); 1 at all other times, including reads and refresh.
- Bank 3: accept -> BERR_ACK one cycle (ACK=BERR=1, no strobes/banks) -> IDLE.
- Refresh: free-running down-counter; on reaching 0 set pending, reload T_REF. In IDLE, pending beats a simultaneous REQ (READY=0). REF_CAS T_CSR cycles: CAS=1, BANK0..2=1, RAS=0. REF_RAS T_RAS_REF cycles: RAS=CAS=1, banks=1. Then PRE, IDLE. Pending cleared on entry to REF_CAS; tick on the same edge sets it again (tick wins).
- Tick during an access: access completes unaltered; refresh starts right after PRE.
- Reset mid-operation: next cycle all strobes drop to reset values (tRAS violation accepted); captured request is discarded, no ACK.
- Counters sized by clog2 of largest parameter; no wrap other than refresh reload.

Decomposition:
- Package mem_dram_pkg: state enum, bank field encodings (BANK_0..BANK_2, BANK_INVALID=3), ADDR field bit positions, default timing constants.
- Sub-module mem_dram_refresh_timer: interval counter + pending flag with clear input; FSM and phase counter stay in mem_dram_ctl.

Test Plan:
- Read ADDR={2'b01,10'h155,10'h2AA} accepted at k -> k+1..k+2 AA=0x155,BANK1=1,RAS=1,CAS=0; k+3..k+5 AA=0x2AA,CAS=1; ACK at k+5 only; MWRITE50_n=1 throughout; READY=1 at k+9.
- Write ADDR={2'b10,10'h3FF,10'h000} -> BANK2 only; MWRITE50_n=0 exactly k+2..k+5; ACK at k+5, BERR=0.
- ADDR bank=3 -> ACK=BERR=1 at k+1; RAS/CAS/BANK* stay 0; READY=1 at k+2.
- Idle after reset, REQ held high -> tick at cycle 390: READY=0; 1 cycle CAS=1,all BANK=1,RAS=0; 3 cycles RAS=CAS=1; 3 PRE cycles; then REQ accepted, MWRITE50_n=1 throughout refresh.
- Tick landing in COL of a read -> ACK at normal cycle, refresh REF_CAS starts in the cycle after the last PRE cycle, no IDLE acceptance between.
- sys_rst asserted for 1 cycle during COL of a write -> next cycle RAS=CAS=0, MWRITE50_n=1, banks 0, no ACK; READY=1 cycle after release; next refresh 390 cycles after release.
